hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
Sequential multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the EX stage and receives the same sr/tg operands. It executes MULT/MULTU/DIV/DIVU iteratively over multiple cycles and raises busy so the pipeline stalls. It also serves MTHI/MTLO writes, and its HI/LO values feed MFHI/MFLO into the write-back mux.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported.
ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch the operation in op with operands sr/tg
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
sr  input  32  rs operand (multiplicand / dividend)
tg  input  32  rt operand (multiplier / divisor)
mthi  input  1  write sr into HI
mtlo  input  1  write sr into LO
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  operation in progress; pipeline must stall MF/MT/MD instructions
done  output  1  one-cycle pulse: hi/lo just updated by a finished operation

Behaviour:
- Reset: clk and reset are one clock; reset is asynchronous, active-low (rst_n). While rst_n=0: hi=0, lo=0, busy=0, done=0, FSM=IDLE, internal accumulators cleared.
- Reset mid-operation aborts the operation; HI/LO go to 0, no done pulse.
- FSM states and transitions:
  - IDLE: start=1 at a rising edge -> RUN.
  - RUN: 32 cycles, one shift/add (mul) or shift/subtract (restoring div) step per cycle; after the 32nd -> FIX.
  - FIX: 1 cycle of sign correction; at its closing edge HI/LO are written -> IDLE.
- Start edge capture: at the start edge, latch op, |sr|, |tg| (signed ops take two's-complement magnitude, unsigned ops pass through) and both operand signs. sr/tg may change afterwards.
- Timing:
  - busy=1 from the cycle after the start edge through the FIX cycle: 33 cycles.
  - done=1 and new hi/lo are visible in the first cycle after FIX, which is also the first cycle with busy=0.
  - Start edge to done = 34 cycles.
- start while busy=1: ignored, no queuing.
- mthi/mtlo in IDLE: the register is written at the edge and is visible next cycle. Both may assert in the same cycle, writing sr to both.
- mthi/mtlo while busy: ignored.
- start with mthi/mtlo in the same IDLE cycle: start wins and the MT write is discarded.
- Multiply: the 64-bit unsigned product of the magnitudes is negated in FIX if the signs differ (signed op only). HI = product[63:32], LO = product[31:0].
- Divide: LO = quotient, HI = remainder, truncation toward zero. Signed: quotient negated if the signs differ; remainder takes the sign of the dividend.
- Divide by zero (tg=0), both DIV and DIVU: runs the full 34 cycles; LO=0xFFFFFFFF, HI=sr as latched (original, not magnitude).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, with no exception signal.
- done stays low on MT writes and during reset.
- hi/lo hold their old values for the whole operation until the write edge.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> hi=lo=0, busy=0, done=0 immediately. Release, then mthi sr=0x12345678 -> hi=0x12345678 next cycle, lo=0, done=0.
- MULT sr=0xFFFFFFFD (-3), tg=5 -> busy high for 33 cycles, done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU sr=tg=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU sr=16, tg=3 -> lo=5, hi=1. DIV sr=0xFFFFFFF9 (-7), tg=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIV sr=0x00000010, tg=0 -> lo=0xFFFFFFFF, hi=0x00000010, done at cycle 34.
- Busy interference: during a MULTU 7*6, assert start (op=DIVU), mtlo, and change sr/tg at cycle 10 -> all ignored; lo=42, hi=0; done pulses exactly once.
- Abort: start MULT, drop rst_n at cycle 20 -> hi=lo=0, busy=0; no done pulse after release. Then start with mthi in the same cycle -> MT discarded; result matches start only.

Source files
------------

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift/add multiply and restoring divide on magnitudes, with sign fix-up in a final cycle.
module hilo_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_sr,
  input  logic [WIDTH-1:0] i_tg,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CntW = $clog2(ITER);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [CntW-1:0]      r_cnt;
  logic [1:0]           r_op;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic [WIDTH-1:0]     r_sr_orig;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_mag_sr;
  logic [WIDTH-1:0]     w_mag_tg;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH+1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;
  logic                 w_idle;

  assign w_idle   = (r_state == StIdle);
  assign w_signed = ~i_op[0];
  assign w_mag_sr = (w_signed && i_sr[WIDTH-1]) ? -i_sr : i_sr;
  assign w_mag_tg = (w_signed && i_tg[WIDTH-1]) ? -i_tg : i_tg;

  // One iteration of each algorithm; r_acc holds {upper, lower} working halves.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
    if (w_diff[WIDTH+1]) begin
      w_div_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    w_prod   = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    w_quot   = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem    = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_op[1]) begin
      if (r_b == '0) begin
        w_res_hi = r_sr_orig;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (r_cnt == CntW'(ITER - 1)) w_state_next = StFix;
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_sr_orig <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == StFix);
      if (w_idle && i_start) begin
        r_cnt     <= '0;
        r_op      <= i_op;
        r_neg_a   <= w_signed & i_sr[WIDTH-1];
        r_neg_b   <= w_signed & i_tg[WIDTH-1];
        r_sr_orig <= i_sr;
        r_b       <= i_op[1] ? w_mag_tg : w_mag_sr;
        r_acc     <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag_sr : w_mag_tg)};
      end else if (w_idle) begin
        // MT writes only land when no operation is being launched.
        if (i_mthi) r_hi <= i_sr;
        if (i_mtlo) r_lo <= i_sr;
      end else if (r_state == StRun) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_op[1] ? w_div_next : w_mul_next;
      end else if (r_state == StFix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = ~w_idle;
  assign o_done = r_done;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed-vector bench for hilo_muldiv: table of operations plus reset, MT and busy sequences.
module tb_hilo_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] sr;
  logic [31:0] tg;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_chk;
  int n_err;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] sr;
    logic [31:0] tg;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  hilo_muldiv #(.WIDTH(32), .ITER(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_op    (op),
    .i_sr    (sr),
    .i_tg    (tg),
    .i_mthi  (mthi),
    .i_mtlo  (mtlo),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one operation and check the busy window, done timing and result.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic with_mthi);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic        bad;
    @(negedge clk);
    old_hi = hi;
    old_lo = lo;
    start  = 1'b1;
    op     = o;
    sr     = a;
    tg     = b;
    mthi   = with_mthi;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    sr    = $urandom;
    tg    = $urandom;
    bad   = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (!(busy === 1'b1 && done === 1'b0 && hi === old_hi && lo === old_lo)) bad = 1'b1;
      @(negedge clk);
    end
    check({name, " busy_window"}, {31'd0, bad}, 32'd0);
    check({name, " done"}, {31'd0, done}, 32'd1);
    check({name, " busy_clear"}, {31'd0, busy}, 32'd0);
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
    @(negedge clk);
    check({name, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    sr    = '0;
    tg    = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;

    vecs[0]  = '{2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{2'd3, 32'd16,       32'd3,        32'd1,        32'd5};
    vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'd2, 32'h00000010, 32'd0,        32'h00000010, 32'hFFFFFFFF};
    vecs[6]  = '{2'd3, 32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF};
    vecs[7]  = '{2'd2, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[8]  = '{2'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
    vecs[9]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{2'd3, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF};
    vecs[12] = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    // Reset, MT writes, asynchronous reset mid-cycle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    sr = 32'hCAFEF00D; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both hi", hi, 32'hCAFEF00D);
    check("mt_both lo", lo, 32'hCAFEF00D);
    check("mt_both done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst hi", hi, 32'd0);
    check("async_rst lo", lo, 32'd0);
    check("async_rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sr = 32'h12345678; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi hi", hi, 32'h12345678);
    check("mthi lo", lo, 32'd0);
    check("mthi done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sr, vecs[i].tg,
             vecs[i].hi, vecs[i].lo, 1'b0);
    end

    // Busy interference: start/mtlo/operand changes mid-operation are ignored
    @(negedge clk);
    start = 1'b1; op = 2'd1; sr = 32'd7; tg = 32'd6;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin
        start = 1'b1; op = 2'd3; mtlo = 1'b1; sr = 32'd99; tg = 32'd0;
      end
      if (c == 11) begin
        start = 1'b0; mtlo = 1'b0;
      end
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("interf done_count", n_done, 32'd1);
    check("interf hi", hi, 32'd0);
    check("interf lo", lo, 32'd42);
    check("interf busy", {31'd0, busy}, 32'd0);

    // Abort by reset at cycle 20 of a MULT
    sr = 32'h0000AAAA; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    start = 1'b1; op = 2'd0; sr = 32'd123; tg = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) n_done++;
      @(negedge clk);
    end
    check("abort no_done", n_done, 32'd0);

    // Start together with mthi: the MT write is dropped
    run_op("start_mthi", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
